// File: rtl/online_pkg.sv
// ----------------------------------------------------------------------------
// online_pkg
// Shared definitions for the online signed-digit datapath: the 2-bit digit
// encoding {plus,minus} and the state type of the stream collector. The online
// adder and its bench use the same definitions.
// ----------------------------------------------------------------------------
package online_pkg;

    typedef logic [1:0] digit_t;

    localparam digit_t DIG_POS  = 2'b10;
    localparam digit_t DIG_NEG  = 2'b01;
    localparam digit_t DIG_ZERO = 2'b00;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/otf_conv_reg.sv
// ----------------------------------------------------------------------------
// otf_conv_reg
// On-the-fly conversion register pair (Q / QM = Q-1). It converts an
// MSD-first radix-2 signed-digit stream to two's complement without a
// carry-propagate adder.
// Ports:
//   clk, asyn_reset_n : clock, async active-low reset
//   en                : a digit is accepted this cycle
//   clr               : with en, return Q/QM to 0/-1 after this digit
//   digit             : signed digit {plus,minus}; 11 is treated as 0
//   q                 : current Q
//   q_nxt             : Q after applying digit (the value the word takes)
// ----------------------------------------------------------------------------
module otf_conv_reg
    import online_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         asyn_reset_n,
    input  logic         en,
    input  logic         clr,
    input  digit_t       digit,
    output logic [W-1:0] q,
    output logic [W-1:0] q_nxt
);

    logic [W-1:0] q_q,  q_d;
    logic [W-1:0] qm_q, qm_d;
    logic [W-1:0] q_upd, qm_upd;

    // Shift left and append; the MSB drops off, which is safe because the
    // result magnitude always fits in W bits.
    always_comb begin
        q_upd  = {q_q[W-2:0], 1'b0};
        qm_upd = {qm_q[W-2:0], 1'b1};
        case (digit)
            DIG_POS: begin
                q_upd  = {q_q[W-2:0], 1'b1};
                qm_upd = {q_q[W-2:0], 1'b0};
            end
            DIG_NEG: begin
                q_upd  = {qm_q[W-2:0], 1'b1};
                qm_upd = {qm_q[W-2:0], 1'b0};
            end
            default: begin
                q_upd  = {q_q[W-2:0], 1'b0};
                qm_upd = {qm_q[W-2:0], 1'b1};
            end
        endcase
    end

    always_comb begin
        q_d  = q_q;
        qm_d = qm_q;
        if (en) begin
            if (clr) begin
                q_d  = '0;
                qm_d = '1;
            end else begin
                q_d  = q_upd;
                qm_d = qm_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            q_q  <= '0;
            qm_q <= '1;
        end else begin
            q_q  <= q_d;
            qm_q <= qm_d;
        end
    end

    assign q     = q_q;
    assign q_nxt = q_upd;

endmodule

// File: rtl/online_otf_collector.sv
// ----------------------------------------------------------------------------
// online_otf_collector
// Sink of the online signed-digit stream. Collects N_DIGITS MSD-first digits,
// converts them on the fly to a W_OUT-bit two's-complement word and offers the
// word on a valid/ready handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   COLLECT | accepting digits, digit_in_rdy = 1
//   HOLD    | word presented, digits blocked until word_out_rdy
//
// Build option: ONLINE_OTF_BACK_TO_BACK_EN removes HOLD. word_out becomes an
// independent output register; only the final digit of a word stalls while the
// previous word is still undelivered.
//
// Ports:
//   clk, asyn_reset_n            : clock, async active-low reset
//   digit_in/_vld/_rdy           : digit stream input handshake
//   word_out/_vld/_rdy           : converted word output handshake
//   digit_cnt                    : digits accepted into the current word
// ----------------------------------------------------------------------------
module online_otf_collector
    import online_pkg::*;
#(
    parameter  int N_DIGITS = 8,
    localparam int W_OUT    = N_DIGITS + 1,
    localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             asyn_reset_n,
    input  digit_t           digit_in,
    input  logic             digit_in_vld,
    output logic             digit_in_rdy,
    output logic [W_OUT-1:0] word_out,
    output logic             word_out_vld,
    input  logic             word_out_rdy,
    output logic [CNT_W-1:0] digit_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

    logic [W_OUT-1:0] word_q, word_d;
    logic             vld_q,  vld_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [W_OUT-1:0] q_cur,  q_nxt;
    logic             accept, last, complete;

`ifndef ONLINE_OTF_BACK_TO_BACK_EN
    state_t state_q, state_d;
    assign digit_in_rdy = (state_q == COLLECT);
`else
    assign digit_in_rdy = !vld_q || word_out_rdy || (cnt_q != LAST_CNT);
`endif

    assign accept   = digit_in_vld && digit_in_rdy;
    assign last     = (cnt_q == LAST_CNT);
    assign complete = accept && last;

    otf_conv_reg #(.W(W_OUT)) u_conv (
        .clk          (clk),
        .asyn_reset_n (asyn_reset_n),
        .en           (accept),
        .clr          (last),
        .digit        (digit_in),
        .q            (q_cur),
        .q_nxt        (q_nxt)
    );

    always_comb begin
        word_d = word_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (accept) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
`ifndef ONLINE_OTF_BACK_TO_BACK_EN
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (complete) begin
                    word_d  = q_nxt;
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (word_out_rdy) begin
                    vld_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
`else
        // Delivery and completion in the same cycle: the new word wins and
        // valid stays high.
        if (vld_q && word_out_rdy) begin
            vld_d = 1'b0;
        end
        if (complete) begin
            word_d = q_nxt;
            vld_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            word_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
`ifndef ONLINE_OTF_BACK_TO_BACK_EN
            state_q <= COLLECT;
`endif
        end else begin
            word_q  <= word_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
`ifndef ONLINE_OTF_BACK_TO_BACK_EN
            state_q <= state_d;
`endif
        end
    end

    assign word_out     = word_q;
    assign word_out_vld = vld_q;
    assign digit_cnt    = cnt_q;

    // Q is only observed through q_nxt; the live value is kept for visibility.
    logic unused_q;
    assign unused_q = ^q_cur;

endmodule

// File: tb/tb_online_otf_collector.sv
// ----------------------------------------------------------------------------
// tb_online_otf_collector
// Directed bench for online_otf_collector with N_DIGITS=4 (W_OUT=5).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_online_otf_collector;
    import online_pkg::*;

    localparam int N = 4;

    logic       clk;
    logic       asyn_reset_n;
    digit_t     digit_in;
    logic       digit_in_vld;
    logic       digit_in_rdy;
    logic [4:0] word_out;
    logic       word_out_vld;
    logic       word_out_rdy;
    logic [1:0] digit_cnt;

    int n_vec = 0;
    int n_err = 0;
    int w;

    localparam digit_t P = DIG_POS;
    localparam digit_t M = DIG_NEG;
    localparam digit_t Z = DIG_ZERO;

    online_otf_collector #(.N_DIGITS(N)) dut (
        .clk          (clk),
        .asyn_reset_n (asyn_reset_n),
        .digit_in     (digit_in),
        .digit_in_vld (digit_in_vld),
        .digit_in_rdy (digit_in_rdy),
        .word_out     (word_out),
        .word_out_vld (word_out_vld),
        .word_out_rdy (word_out_rdy),
        .digit_cnt    (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one digit and return on the falling edge after it was accepted.
    task automatic push(input digit_t d, output int waits);
        waits        = 0;
        digit_in     = d;
        digit_in_vld = 1'b1;
        #1;
        while (!digit_in_rdy && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!digit_in_rdy) begin
            chk("accept_timeout", 32'(waits), 0);
            digit_in_vld = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic push4(input digit_t d0, input digit_t d1, input digit_t d2, input digit_t d3);
        int wt;
        push(d0, wt);
        push(d1, wt);
        push(d2, wt);
        push(d3, wt);
        digit_in_vld = 1'b0;
    endtask

    task automatic get_word(input string tag, input logic [4:0] exp);
        int n = 0;
        while (!word_out_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, 32'(word_out_vld), 1);
        chk(tag, 32'(word_out), 32'(exp));
        @(negedge clk);
    endtask

    digit_t     seq [12];
    logic [4:0] exp_w [3];

    initial begin
        asyn_reset_n = 1'b0;
        digit_in     = Z;
        digit_in_vld = 1'b0;
        word_out_rdy = 1'b1;
        seq   = '{P, Z, M, P,  M, M, M, M,  P, P, P, P};
        exp_w = '{5'b00111, 5'b10001, 5'b01111};

        #12;
        chk("rst_word", 32'(word_out), 0);
        chk("rst_vld", 32'(word_out_vld), 0);
        chk("rst_cnt", 32'(digit_cnt), 0);
        @(negedge clk);
        asyn_reset_n = 1'b1;
        #1;
        chk("rst_rdy", 32'(digit_in_rdy), 1);
        @(negedge clk);

        // +1,0,-1,+1 back to back -> 7
        push(P, w); chk("t1_cnt1", 32'(digit_cnt), 1);
        push(Z, w); chk("t1_cnt2", 32'(digit_cnt), 2);
        push(M, w); chk("t1_cnt3", 32'(digit_cnt), 3);
        chk("t1_vld_early", 32'(word_out_vld), 0);
        push(P, w);
        digit_in_vld = 1'b0;
        chk("t1_vld", 32'(word_out_vld), 1);
        chk("t1_word", 32'(word_out), 32'(5'b00111));
        chk("t1_cnt0", 32'(digit_cnt), 0);
`ifndef ONLINE_OTF_BACK_TO_BACK_EN
        chk("t1_rdy_low", 32'(digit_in_rdy), 0);
`else
        chk("t1_rdy_high", 32'(digit_in_rdy), 1);
`endif
        @(negedge clk);
        chk("t1_vld_drop", 32'(word_out_vld), 0);
        chk("t1_rdy_back", 32'(digit_in_rdy), 1);

        // all -1 and all +1
        push4(M, M, M, M);
        get_word("t2_neg15", 5'b10001);
        push4(P, P, P, P);
        get_word("t3_pos15", 5'b01111);

        // 0,+1,11,-1 with gaps -> 3
        push(Z, w);     digit_in_vld = 1'b0; @(negedge clk); chk("t4_gap1", 32'(digit_cnt), 1);
        push(P, w);     digit_in_vld = 1'b0; @(negedge clk); chk("t4_gap2", 32'(digit_cnt), 2);
        push(2'b11, w); digit_in_vld = 1'b0; @(negedge clk); chk("t4_gap3", 32'(digit_cnt), 3);
        push(M, w);     digit_in_vld = 1'b0;
        get_word("t4_code11", 5'b00011);

        // +1,+1,0,-1 -> 11 held with word_out_rdy low
        word_out_rdy = 1'b0;
        push4(P, P, Z, M);
`ifndef ONLINE_OTF_BACK_TO_BACK_EN
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_word", 32'(word_out), 32'(5'd11));
            chk("t5_hold_vld", 32'(word_out_vld), 1);
            chk("t5_hold_rdy", 32'(digit_in_rdy), 0);
            @(negedge clk);
        end
        word_out_rdy = 1'b1;
        @(negedge clk);
        chk("t5_release", 32'(word_out_vld), 0);
`else
        chk("t5_word", 32'(word_out), 32'(5'd11));
        push(P, w); chk("t5_ovl_wait", 32'(w), 0);
        push(Z, w); chk("t5_ovl_wait", 32'(w), 0);
        push(Z, w); chk("t5_ovl_wait", 32'(w), 0);
        chk("t5_hold_word", 32'(word_out), 32'(5'd11));
        digit_in = M;
        #1;
        chk("t5_last_stall", 32'(digit_in_rdy), 0);
        @(negedge clk);
        #1;
        chk("t5_stall_cnt", 32'(digit_cnt), 3);
        word_out_rdy = 1'b1;
        #1;
        chk("t5_last_rdy", 32'(digit_in_rdy), 1);
        @(negedge clk);
        digit_in_vld = 1'b0;
        chk("t5_new_word", 32'(word_out), 32'(5'd7));
        chk("t5_new_vld", 32'(word_out_vld), 1);
        @(negedge clk);
        chk("t5_drained", 32'(word_out_vld), 0);
`endif

        // async reset mid-word, then +1,-1,0,0 -> 4
        push(P, w);
        push(P, w);
        digit_in_vld = 1'b0;
        chk("t6_cnt2", 32'(digit_cnt), 2);
        #2;
        asyn_reset_n = 1'b0;
        #1;
        chk("t6_async_cnt", 32'(digit_cnt), 0);
        chk("t6_async_word", 32'(word_out), 0);
        chk("t6_async_vld", 32'(word_out_vld), 0);
        #1;
        asyn_reset_n = 1'b1;
        @(negedge clk);
        chk("t6_rdy", 32'(digit_in_rdy), 1);
        push4(P, M, Z, Z);
        get_word("t6_after_rst", 5'b00100);

`ifdef ONLINE_OTF_BACK_TO_BACK_EN
        // continuous stream of three words
        for (int i = 0; i < 12; i++) begin
            push(seq[i], w);
            chk("t7_no_stall", 32'(w), 0);
            if (i % 4 == 3) begin
                chk("t7_vld", 32'(word_out_vld), 1);
                chk("t7_word", 32'(word_out), 32'(exp_w[i / 4]));
            end
        end
        digit_in_vld = 1'b0;
        @(negedge clk);
        chk("t7_drained", 32'(word_out_vld), 0);
`else
        // same three words through the two-state path
        for (int i = 0; i < 3; i++) begin
            push4(seq[4*i], seq[4*i+1], seq[4*i+2], seq[4*i+3]);
            get_word("t7_word", exp_w[i]);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/online_otf_collector.md
Name: online_otf_collector

Overview:
- Sink end of the online signed-digit stream: consumes the MSD-first radix-2 digit stream emitted by the online adder over its valid/ready handshake.
- Converts the stream to a two's-complement word using on-the-fly conversion (Q/QM registers), with no carry-propagate adder.
- Presents one word per N_DIGITS accepted digits on a valid/ready output handshake.
- Sits downstream of the online adder, feeding conventional-arithmetic logic and checkers.

Parameters:
- N_DIGITS, 8, digits per word; digit j (j=0..N_DIGITS-1) has weight 2^(N_DIGITS-1-j).
- W_OUT, N_DIGITS+1, output width; fixed relation, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- asyn_reset_n  input  1  asynchronous, active-low reset.
- digit_in  input  2  signed digit {plus,minus}; 10=+1, 01=-1, 00=0, 11=0.
- digit_in_vld  input  1  digit_in valid.
- digit_in_rdy  output  1  collector accepts a digit this cycle.
- word_out  output  W_OUT  two's-complement result R = sum d_j*2^(N_DIGITS-1-j).
- word_out_vld  output  1  word_out valid.
- word_out_rdy  input  1  downstream accepts word_out.
- digit_cnt  output  clog2(N_DIGITS)  digits accepted into the current word.

Behaviour:
- Interface decision: one clock, clk. Reset asyn_reset_n is asynchronous and active-low.
- Reset values:
  - word_out = 0, word_out_vld = 0, digit_cnt = 0.
  - digit_in_rdy = 1 once reset is released; state = COLLECT.
  - Q = 0, QM = all ones (-1).
- A digit is accepted when digit_in_vld && digit_in_rdy at a rising clk edge. A word is delivered when word_out_vld && word_out_rdy.
- On-the-fly update per accepted digit, W_OUT-bit shift-left, MSB dropped:
  - d=+1: Q <= {Q,1}, QM <= {Q,0}.
  - d=0: Q <= {Q,0}, QM <= {QM,1}.
  - d=-1: Q <= {QM,1}, QM <= {QM,0}.
  - Invariant: QM == Q-1 modulo 2^W_OUT at all times.
- Code 11 is treated exactly as 0.
- FSM states are COLLECT and HOLD.
- COLLECT:
  - digit_in_rdy = 1.
  - Each accept increments digit_cnt.
  - On accepting digit N_DIGITS-1:
    - word_out <= the updated Q value (the conversion including this digit).
    - word_out_vld <= 1 on the next edge; state -> HOLD.
    - digit_cnt -> 0; Q/QM -> reset values.
  - Latency: word_out_vld is high in the cycle after the last digit is accepted.
- HOLD:
  - digit_in_rdy = 0; word_out is stable.
  - On word_out_rdy, word_out_vld <= 0 and state -> COLLECT.
- Throughput without the optional feature: N_DIGITS+1 cycles per word.
- digit_in_vld low stalls conversion indefinitely. Q, QM and digit_cnt hold.
- Reset asserted mid-word discards the partial word. Reset asserted during HOLD drops the pending word.
- No overflow is possible: |R| <= 2^N_DIGITS-1 fits in W_OUT bits.

Optional Feature:
- Macro: ONLINE_OTF_BACK_TO_BACK_EN.
- Defined:
  - HOLD state is removed; word_out is an independent output register.
  - digit_in_rdy = !word_out_vld || word_out_rdy || (digit_cnt != N_DIGITS-1).
  - The first digits of the next word are accepted while the previous word awaits word_out_rdy. Only the final digit stalls.
  - If the word is delivered and a new word completes in the same cycle, word_out loads the new value and word_out_vld stays 1.
  - Sustained throughput: 1 word per N_DIGITS cycles.
- Undefined: the two-state behaviour above.

Decomposition:
- Package online_pkg holds:
  - Digit encoding constants DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO=2'b00.
  - State typedef {COLLECT, HOLD}.
  - Digit-type typedef (2-bit).
  - These are shared with the online adder and its bench.
- One sub-module, otf_conv_reg. It holds the Q/QM register pair with inputs for digit, enable and clear. The top level owns the FSM, counter and handshake.

Test Plan (N_DIGITS=4, W_OUT=5):
- Digits +1,0,-1,+1 back to back with word_out_rdy=1 -> word_out=5'b00111 (7), word_out_vld 1 cycle after the 4th accept, digit_in_rdy low for exactly 1 cycle.
- Digits -1,-1,-1,-1 -> 5'b10001 (-15). Digits +1,+1,+1,+1 -> 5'b01111 (15).
- Digits 0,+1,11,-1 with digit_in_vld toggling every other cycle -> 5'b00011 (3), digit_cnt holds during gaps, and code 11 is treated as 0.
- Word completed with word_out_rdy=0 for 5 cycles -> word_out stable, digit_in_rdy=0 throughout (macro off). With the macro on, 3 digits of the next word are accepted, then the bench stalls until delivery.
- asyn_reset_n pulsed low after 2 digits, asynchronously between edges -> outputs go immediately to reset values. Next 4 digits +1,-1,0,0 -> 5'b00100 (4), with no residue from the partial word.
- Macro on, continuous stream of 3 words, word_out_rdy=1 -> one word every 4 cycles, digit_in_rdy never drops.
